// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: controller state encoding, initial hash value
// and the index of the last round.
package sha256_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_INIT   = 2'd1,
        ST_ROUNDS = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [31:0] SHA256_H0_0 = 32'h6a09e667;
    localparam logic [31:0] SHA256_H0_1 = 32'hbb67ae85;
    localparam logic [31:0] SHA256_H0_2 = 32'h3c6ef372;
    localparam logic [31:0] SHA256_H0_3 = 32'ha54ff53a;
    localparam logic [31:0] SHA256_H0_4 = 32'h510e527f;
    localparam logic [31:0] SHA256_H0_5 = 32'h9b05688c;
    localparam logic [31:0] SHA256_H0_6 = 32'h1f83d9ab;
    localparam logic [31:0] SHA256_H0_7 = 32'h5be0cd19;

    localparam logic [5:0] SHA256_LOOP_LAST = 6'd63;

endpackage

// File: rtl/sha256_core_standard_ctrl.sv
// Sequencer for the standard SHA-256 round datapath: one block per handshake,
// INIT + 64 rounds + DONE, digest held on a valid/ready output and chained back.
module sha256_core_standard_ctrl
    import sha256_pkg::*;
#(
    parameter logic [6:0] ROUND_WATCHDOG = 7'd66
) (
    input  logic         clk,
    input  logic         reset,

    input  logic         block_valid,
    input  logic         block_first,
    input  logic [511:0] block_data,
    output logic         block_ready,

    output logic         digest_valid,
    input  logic         digest_ready,
    output logic [255:0] digest_out,

    output logic         busy,
    output logic         error,

    input  logic         t_ctr_last,
    input  logic [255:0] dp_digest,
    output logic         t_ctr_init,
    output logic         t_ctr_next,
    output logic         digest_init,
    output logic         loop_init,
    output logic         loop_next,
    output logic         w_init,
    output logic         w_next,
    output logic [511:0] dp_block,
    output logic         dp_first_block,
    output logic [255:0] dp_prev_digest
);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [6:0] r_round_ctr;
    logic       w_accept;
    logic       w_consume;
    logic       w_timeout;

    assign w_accept  = block_valid & block_ready;
    assign w_consume = digest_valid & digest_ready;
    // Abort only if the datapath never reported its last round in time.
    assign w_timeout = (r_state == ST_ROUNDS) && !t_ctr_last &&
                       (r_round_ctr == (ROUND_WATCHDOG - 7'd1));

    assign dp_prev_digest = digest_out;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_accept) w_state_nxt = ST_INIT;
            ST_INIT:   w_state_nxt = ST_ROUNDS;
            ST_ROUNDS: begin
                if (t_ctr_last) begin
                    w_state_nxt = ST_DONE;
                end else if (w_timeout) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DONE:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        t_ctr_init  = 1'b0;
        t_ctr_next  = 1'b0;
        digest_init = 1'b0;
        loop_init   = 1'b0;
        loop_next   = 1'b0;
        w_init      = 1'b0;
        w_next      = 1'b0;
        block_ready = 1'b0;
        busy        = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE: block_ready = !digest_valid;
            ST_INIT: begin
                t_ctr_init  = 1'b1;
                digest_init = 1'b1;
                loop_init   = 1'b1;
                w_init      = 1'b1;
            end
            ST_ROUNDS: begin
                loop_next  = 1'b1;
                w_next     = 1'b1;
                // Hold the datapath counter at 63 on the final round.
                t_ctr_next = !t_ctr_last;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_round_ctr    <= 7'd0;
            error          <= 1'b0;
            digest_valid   <= 1'b0;
            digest_out     <= 256'd0;
            dp_block       <= 512'd0;
            dp_first_block <= 1'b1;
        end else begin
            if (w_accept) begin
                dp_block       <= block_data;
                dp_first_block <= block_first;
            end
            if (r_state == ST_INIT) begin
                r_round_ctr <= 7'd0;
            end else if (r_state == ST_ROUNDS) begin
                r_round_ctr <= r_round_ctr + 7'd1;
            end
            if (w_timeout) begin
                error <= 1'b1;
            end
            if (r_state == ST_DONE) begin
                digest_out   <= dp_digest;
                digest_valid <= 1'b1;
            end else if (w_consume) begin
                digest_valid <= 1'b0;
            end
        end
    end

endmodule
